// File: rtl/fb_swap_sched_pkg.sv
// Shared types for the triple-buffer swap scheduler: per-buffer state, index type
// and a state-search helper used by the scheduler and its free-buffer picker.
package fb_swap_sched_pkg;

  localparam int num_bufs_lp = 3;

  typedef enum logic [2:0] {
    BUF_FREE,
    BUF_WRITING,
    BUF_READY,
    BUF_READING,
    BUF_SHOWN
  } buf_state_t;

  typedef logic [1:0] buf_idx_t;

  typedef buf_state_t buf_states_t [num_bufs_lp];

  typedef struct packed {
    logic     found;
    buf_idx_t idx;
  } buf_hit_t;

  // Lowest-index buffer currently in the target state.
  function automatic buf_hit_t find_state(buf_states_t states, buf_state_t target);
    buf_hit_t hit;
    hit = '0;
    for (int i = num_bufs_lp - 1; i >= 0; i--) begin
      if (states[i] == target) begin
        hit.found = 1'b1;
        hit.idx   = buf_idx_t'(i);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/fb_swap_sched_free_pick.sv
// Combinational lowest-index FREE buffer finder for the swap scheduler.
module fb_free_pick
  import fb_swap_sched_pkg::*;
(
  input  buf_states_t states,
  output buf_idx_t    idx,
  output logic        found
);

  buf_hit_t hit;

  assign hit   = find_state(states, BUF_FREE);
  assign idx   = hit.idx;
  assign found = hit.found;

endmodule

// File: rtl/fb_swap_sched.sv
// Triple-buffer index scheduler: grants buffers to a frame writer and a frame reader.
// Define FB_SWAP_SCHED_REPEAT_EN to let the reader re-acquire the last shown frame.
module fb_swap_sched
  import fb_swap_sched_pkg::*;
#(
  parameter int frame_id_width_p   = 8,
  parameter int drop_count_width_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          wr_acq_valid_i,
  output logic                          wr_acq_ready_o,
  input  logic                          wr_done_i,
  input  logic                          wr_abort_i,
  output logic                          wr_active_o,
  output logic [1:0]                    wr_buf_o,
  input  logic                          rd_acq_valid_i,
  output logic                          rd_acq_ready_o,
  input  logic                          rd_done_i,
  output logic                          rd_active_o,
  output logic [1:0]                    rd_buf_o,
  output logic [frame_id_width_p-1:0]   rd_frame_id_o,
  output logic                          frame_avail_o,
  output logic [drop_count_width_p-1:0] drop_count_o,
`ifdef FB_SWAP_SCHED_REPEAT_EN
  output logic                          rd_repeat_o,
`endif
  output logic                          err_o
);

  localparam logic [frame_id_width_p-1:0]   id_one_lp   = 1;
  localparam logic [drop_count_width_p-1:0] drop_one_lp = 1;

  buf_states_t                 state_q;
  logic [frame_id_width_p-1:0] tag_q [num_bufs_lp];
  logic [frame_id_width_p-1:0] next_id_q;

  buf_idx_t free_idx;
  logic     free_found;
  buf_hit_t ready_hit;

  fb_free_pick u_free_pick (
    .states (state_q),
    .idx    (free_idx),
    .found  (free_found)
  );

  assign ready_hit = find_state(state_q, BUF_READY);

`ifdef FB_SWAP_SCHED_REPEAT_EN
  buf_hit_t shown_hit;
  assign shown_hit      = find_state(state_q, BUF_SHOWN);
  assign rd_acq_ready_o = !rd_active_o && (ready_hit.found || shown_hit.found);
`else
  assign rd_acq_ready_o = !rd_active_o && ready_hit.found;
`endif

  assign wr_acq_ready_o = !wr_active_o;
  assign frame_avail_o  = ready_hit.found;

  logic wr_grant, wr_abort_ok, wr_commit, rd_grant, rd_release, err_set;

  assign wr_grant    = wr_acq_valid_i && wr_acq_ready_o && free_found;
  assign wr_abort_ok = wr_abort_i && wr_active_o;
  assign wr_commit   = wr_done_i && !wr_abort_i && wr_active_o;
  assign rd_grant    = rd_acq_valid_i && rd_acq_ready_o;
  assign rd_release  = rd_done_i && rd_active_o;
  assign err_set     = ((wr_done_i || wr_abort_i) && !wr_active_o)
                     || (wr_done_i && wr_abort_i)
                     || (rd_done_i && !rd_active_o);

  // Each event targets a distinct buffer, so the per-buffer updates never collide.
  // NOTE: sequential state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < num_bufs_lp; i++) state_q[i] <= BUF_FREE;
      next_id_q     <= '0;
      wr_active_o   <= 1'b0;
      wr_buf_o      <= '0;
      rd_active_o   <= 1'b0;
      rd_buf_o      <= '0;
      rd_frame_id_o <= '0;
      drop_count_o  <= '0;
      err_o         <= 1'b0;
`ifdef FB_SWAP_SCHED_REPEAT_EN
      rd_repeat_o   <= 1'b0;
`endif
    end else begin
      if (err_set) err_o <= 1'b1;

      if (wr_grant) begin
        state_q[free_idx] <= BUF_WRITING;
        wr_active_o       <= 1'b1;
        wr_buf_o          <= free_idx;
      end

      if (wr_abort_ok) begin
        state_q[wr_buf_o] <= BUF_FREE;
        wr_active_o       <= 1'b0;
      end

      // NOTE: tag_q is storage qualified by state_q, so it deliberately has no reset.
      if (wr_commit) begin
        state_q[wr_buf_o] <= BUF_READY;
        tag_q[wr_buf_o]   <= next_id_q;
        next_id_q         <= next_id_q + id_one_lp;
        wr_active_o       <= 1'b0;
        if (ready_hit.found && !rd_grant) begin
          state_q[ready_hit.idx] <= BUF_FREE;
          if (drop_count_o != '1) drop_count_o <= drop_count_o + drop_one_lp;
        end
      end

      if (rd_grant) begin
        rd_active_o <= 1'b1;
`ifdef FB_SWAP_SCHED_REPEAT_EN
        if (ready_hit.found) begin
          state_q[ready_hit.idx] <= BUF_READING;
          rd_buf_o               <= ready_hit.idx;
          rd_frame_id_o          <= tag_q[ready_hit.idx];
          rd_repeat_o            <= 1'b0;
          if (shown_hit.found) state_q[shown_hit.idx] <= BUF_FREE;
        end else begin
          state_q[shown_hit.idx] <= BUF_READING;
          rd_buf_o               <= shown_hit.idx;
          rd_frame_id_o          <= tag_q[shown_hit.idx];
          rd_repeat_o            <= 1'b1;
        end
`else
        state_q[ready_hit.idx] <= BUF_READING;
        rd_buf_o               <= ready_hit.idx;
        rd_frame_id_o          <= tag_q[ready_hit.idx];
`endif
      end

      if (rd_release) begin
        rd_active_o <= 1'b0;
`ifdef FB_SWAP_SCHED_REPEAT_EN
        state_q[rd_buf_o] <= BUF_SHOWN;
`else
        state_q[rd_buf_o] <= BUF_FREE;
`endif
      end
    end
  end

endmodule
